// File: rtl/avg_pool_divider_pkg.sv
// Shared definitions for the average-pooling divider: FSM encoding and the
// Q13 reciprocal format used by the lookup table and the output rounding.
package avg_pool_divider_pkg;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    LOOKUP = 2'd1,
    MULT   = 2'd2,
    OUT    = 2'd3
  } state_t;

  localparam int FRAC_WIDTH  = 16;
  localparam int FRAC_SHIFT  = 13;
  localparam int ROUND_CONST = 4096;
  localparam int INDEX_WIDTH = 6;
  localparam int TABLE_DEPTH = 1 << INDEX_WIDTH;

  localparam logic [FRAC_WIDTH-1:0] FRAC_RESET = 16'hFFFF;

  // floor(1.0 / (idx + 1)) in Q13; index 0 (one sample) yields exactly 1.0.
  function automatic logic [FRAC_WIDTH-1:0] recip_q13(input int idx);
    return FRAC_WIDTH'((1 << FRAC_SHIFT) / (idx + 1));
  endfunction

endpackage

// File: rtl/fraction_table.sv
// Registered reciprocal LUT: fraction = floor(8192 / (index + 1)), valid one
// cycle after index is presented.
module fraction_table
  import avg_pool_divider_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INDEX_WIDTH-1:0] index,
  output logic [FRAC_WIDTH-1:0]  fraction
);

  logic [FRAC_WIDTH-1:0] rom [TABLE_DEPTH];

  // Constant contents, so the table is pure logic and needs no reset.
  for (genvar i = 0; i < TABLE_DEPTH; i++) begin : g_rom
    assign rom[i] = recip_q13(i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fraction <= FRAC_RESET;
    end else begin
      fraction <= rom[index];
    end
  end

endmodule

// File: rtl/avg_pool_divider.sv
// Streaming average pool: sums a window of signed samples, multiplies by a
// Q13 reciprocal of the sample count and rounds half toward +infinity.
module avg_pool_divider
  import avg_pool_divider_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_WIN    = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         win_trunc
);

  localparam int ACC_WIDTH  = DATA_WIDTH + 6;
  localparam int PROD_WIDTH = ACC_WIDTH + FRAC_WIDTH + 1;

  localparam logic signed [PROD_WIDTH-1:0] SAT_MAX = PROD_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [PROD_WIDTH-1:0] SAT_MIN = -SAT_MAX - PROD_WIDTH'(1);

  state_t                        state;
  logic signed [ACC_WIDTH-1:0]   sum;
  logic [6:0]                    count;
  logic signed [PROD_WIDTH-1:0]  product;
  logic signed [PROD_WIDTH-1:0]  rounded;
  logic [INDEX_WIDTH-1:0]        recip_index;
  logic [FRAC_WIDTH-1:0]         fraction;

  assign recip_index = INDEX_WIDTH'(count - 7'd1);

  fraction_table u_fraction_table (
    .clk      (clk),
    .rst      (~rst_n),
    .index    (recip_index),
    .fraction (fraction)
  );

  // NOTE: every register below is assigned with <= so all of them update
  // together on the edge; a blocking = here would let later lines see the
  // new value and silently change the pipeline timing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      sum       <= '0;
      count     <= '0;
      product   <= '0;
      out_valid <= 1'b0;
      win_trunc <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      win_trunc <= 1'b0;
      case (state)
        ACCUM: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            sum   <= sum + {{(ACC_WIDTH - DATA_WIDTH){in_data[DATA_WIDTH-1]}}, in_data};
            count <= count + 7'd1;
            if (in_last || count == 7'(MAX_WIN - 1)) begin
              state     <= LOOKUP;
              in_ready  <= 1'b0;
              win_trunc <= ~in_last;
            end
          end
        end
        LOOKUP: state <= MULT;
        MULT: begin
          // Fraction is zero-extended so 1.0 (8192) and up stay positive.
          product   <= PROD_WIDTH'(sum) * PROD_WIDTH'($signed({1'b0, fraction}));
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            sum       <= '0;
            count     <= '0;
            in_ready  <= 1'b1;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  assign rounded = (product + PROD_WIDTH'(ROUND_CONST)) >>> FRAC_SHIFT;

  // NOTE: out_data gets its default before the if-chain, so every path
  // assigns it and no latch is inferred.
  always_comb begin
    out_data = rounded[DATA_WIDTH-1:0];
    if (rounded > SAT_MAX) begin
      out_data = SAT_MAX[DATA_WIDTH-1:0];
    end else if (rounded < SAT_MIN) begin
      out_data = SAT_MIN[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_avg_pool_divider.sv
// Directed and random windows through avg_pool_divider with a result
// scoreboard, latency, truncation, backpressure and mid-pipeline reset.
module tb_avg_pool_divider;

  localparam int DW = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] in_data = '0;
  logic                 in_last = 1'b0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic signed [DW-1:0] out_data;
  logic                 win_trunc;

  int     checks = 0;
  int     errors = 0;
  longint sb[$];
  int     win[$];

  always #5 clk = ~clk;

  avg_pool_divider #(.DATA_WIDTH(DW), .MAX_WIN(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .win_trunc (win_trunc)
  );

  task automatic check(input string tag, input logic signed [39:0] obs,
                       input logic signed [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference average: sum * floor(8192/n), +4096, arithmetic >> 13, saturate.
  function automatic longint model_avg(input longint s, input int n);
    longint p;
    longint r;
    p = s * longint'(8192 / n);
    r = (p + 4096) >>> 13;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  // Results are compared on the falling edge ahead of the handshake edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) check("unexpected_output", out_valid, 0);
      else                check("out_data", out_data, sb.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_sample(input int d, input logic last);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = DW'(d);
    in_last  = last;
    while (!in_ready && guard < 100) begin
      tick();
      guard++;
    end
    if (guard == 100) check("in_ready_timeout", in_ready, 1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(output int edges);
    edges = 0;
    while (!out_valid && edges < 20) begin
      tick();
      edges++;
    end
  endtask

  // Sends win[] with in_last on the final sample, expects exp, out_ready high.
  task automatic run_window(input string tag, input longint exp);
    int e;
    sb.push_back(exp);
    for (int i = 0; i < win.size(); i++) send_sample(win[i], i == win.size() - 1);
    check({tag, "_no_trunc"}, win_trunc, 0);
    wait_out(e);
    check({tag, "_latency"}, e, 2);
    tick();
    check({tag, "_ready_after"}, in_ready, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int     e;
    int     n;
    longint s;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_win_trunc", win_trunc, 0);
    rst_n = 1'b1;
    #1;
    check("in_ready_before_edge", in_ready, 0);
    tick();
    check("in_ready_after_edge", in_ready, 1);

    // Basic averages and rounding on both signs
    win = {100, 100, 100};
    run_window("avg100", 100);
    win = {3, 4};
    run_window("pos_half", 4);
    win = {-3, -4};
    run_window("neg_half", -3);

    // Single most-negative sample, in_ready low for three cycles
    sb.push_back(-32768);
    send_sample(-32768, 1);
    check("single_ready_c1", in_ready, 0);
    tick();
    check("single_ready_c2", in_ready, 0);
    tick();
    check("single_ready_c3", in_ready, 0);
    check("single_valid", out_valid, 1);
    tick();
    check("single_ready_after", in_ready, 1);

    // 64 samples without in_last: truncation pulse, then a fresh window
    sb.push_back(32767);
    for (int i = 0; i < 64; i++) begin
      send_sample(32767, 1'b0);
      if (i == 62) check("trunc_before_64", win_trunc, 0);
    end
    check("trunc_pulse", win_trunc, 1);
    check("trunc_ready_low", in_ready, 0);
    tick();
    check("trunc_pulse_end", win_trunc, 0);
    wait_out(e);
    check("trunc_latency", e, 1);
    tick();
    win = {5};
    run_window("after_trunc", 5);

    // Backpressure: result held, input ignored
    out_ready = 1'b0;
    sb.push_back(20);
    send_sample(10, 1'b0);
    send_sample(20, 1'b0);
    send_sample(31, 1'b1);
    wait_out(e);
    check("bp_latency", e, 2);
    in_valid = 1'b1;
    in_data  = 16'sd999;
    in_last  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("bp_valid_hold", out_valid, 1);
      check("bp_data_hold", out_data, 20);
      check("bp_ready_low", in_ready, 0);
      tick();
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_released", out_valid, 0);
    win = {7};
    run_window("after_bp", 7);

    // Reset while the window sits in MULT
    send_sample(1000, 1'b0);
    send_sample(2000, 1'b1);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ready", in_ready, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("mid_rst_no_output", out_valid, 0);
    end
    win = {5, 6, 7};
    run_window("after_rst", 6);

    // Random windows
    for (int k = 0; k < 5; k++) begin
      n = int'($urandom_range(12, 1));
      win = {};
      s = 0;
      for (int i = 0; i < n; i++) begin
        win.push_back(int'($urandom_range(65535, 0)) - 32768);
        s += win[i];
      end
      run_window("random", model_avg(s, n));
    end

    repeat (3) tick();
    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/avg_pool_divider.md
AVG_POOL_DIVIDER -- requirements
Module: avg_pool_divider

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, signed sample and result width.
REQ-002 SHALL have parameter MAX_WIN, default 64, maximum samples per window (fixed by the 6-bit reciprocal index).
REQ-003 SHALL derive localparam ACC_WIDTH = DATA_WIDTH+6, the signed sum width.
REQ-004 Port clk  input  1  single clock; all logic on rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port in_valid  input  1  sample present.
REQ-007 Port in_ready  output  1  block accepts a sample this cycle.
REQ-008 Port in_data  input  DATA_WIDTH  signed sample.
REQ-009 Port in_last  input  1  final sample of the pooling window.
REQ-010 Port out_valid  output  1  averaged result present.
REQ-011 Port out_ready  input  1  downstream accepts the result.
REQ-012 Port out_data  output  DATA_WIDTH  signed window average.
REQ-013 Port win_trunc  output  1  one-cycle pulse when a window closes at MAX_WIN without in_last.

Function
REQ-014 SHALL implement FSM states ACCUM, LOOKUP, MULT, OUT.
REQ-015 ACCUM: in_ready=1; on in_valid&in_ready add sign-extended in_data to sum and increment count (7 bits).
REQ-016 ACCUM SHALL go to LOOKUP when an accepted sample has in_last=1 or is the MAX_WIN-th sample; the latter without in_last pulses win_trunc.
REQ-017 LOOKUP: drive reciprocal index = count-1 (6 bits); table returns floor(8192/(index+1)) (Q13, 8192=1.0) one cycle later; go to MULT.
REQ-018 MULT: register product = sum (signed) x fraction (zero-extended to 17 bits, signed), ACC_WIDTH+17 bits; go to OUT.
REQ-019 OUT: out_data = saturate_DATA_WIDTH((product + 4096) >>> 13), i.e. round half toward +infinity; out_valid=1.
REQ-020 out_valid and out_data SHALL hold stable until out_ready; on out_valid&out_ready clear sum and count and return to ACCUM.
REQ-021 in_ready SHALL be 0 in LOOKUP, MULT and OUT; no sample is accepted or dropped there.
REQ-022 Latency: closing sample accepted in cycle t -> out_valid first high in cycle t+3.
REQ-023 Throughput: one result per (N+3) cycles minimum for an N-sample window with out_ready held high.
REQ-024 Fraction reset value (16'hFFFF) SHALL never reach out_data; the multiply uses the fraction only in MULT.
REQ-025 Single-sample window (count=1, fraction 8192) SHALL return in_data exactly.

Reset
REQ-026 rst_n low SHALL asynchronously force state ACCUM, sum=0, count=0, out_valid=0, out_data=0, win_trunc=0, product=0.
REQ-027 in_ready SHALL be 0 while rst_n is low and 1 from the first clock edge after deassertion.
REQ-028 Reset during any state SHALL discard the partial window and any pending result; no output follows.

Structure
REQ-029 Shared package SHALL hold the FSM state encoding, FRAC_WIDTH=16, FRAC_SHIFT=13, and ROUND_CONST=4096.
REQ-030 SHALL instantiate the existing fraction_table reciprocal LUT as its only sub-module, its rst input driven by ~rst_n.
REQ-031 Accumulator, multiplier and output registers SHALL be separate pipeline registers; no combinational path from in_data to out_data.

Verification
REQ-032 Window {100,100,100} last on third, out_ready=1 -> out_data=100 (300*2730=819000), out_valid at t+3.
REQ-033 Window {3,4} -> 4 (28672+4096)>>13; window {-3,-4} -> -3; confirms round-half-up on both signs.
REQ-034 Single sample -32768 with in_last -> out_data=-32768, in_ready low for 3 cycles then high after handshake.
REQ-035 64 samples of 32767, in_last never set -> win_trunc pulses on 64th accept, out_data=32767; 65th sample starts a new window.
REQ-036 out_ready held low 10 cycles in OUT -> out_data stable, in_valid ignored; rst_n pulsed in MULT -> out_valid never rises, next window independent.
